// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the serial adder
// Purpose: FSM state encoding and default operand width for serial_add_ctrl.
// Ports: none (package).
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - single-bit full adder from two half adders and an OR
// Purpose: one bit-slice of the serial adder.
// Ports:
//   a, b, ci : input  bits and carry-in
//   s, co    : sum bit and carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p1;
  logic g1;
  logic g2;

  // First half adder: a + b
  assign p1 = a ^ b;
  assign g1 = a & b;

  // Second half adder: partial sum + carry-in
  assign s  = p1 ^ ci;
  assign g2 = p1 & ci;

  assign co = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, one bit per clock
// Purpose: adds two WIDTH-bit operands LSB-first through a single fa_cell.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input (subtract mode).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : request a new operation (sampled in IDLE only)
//   op_a, op_b, cin   : operands and carry-in, captured on accepted start
//   sub               : (SERIAL_ADD_SUB_EN only) 1 = op_a - op_b
//   busy              : high while bits are being processed
//   done              : one-cycle result-valid pulse
//   sum, carry_out    : result and final carry, held until the next result
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry_r;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             fa_s;
  logic             fa_co;
  logic             sub_sel;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_r),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_r   <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= op_a;
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            b_sr    <= sub_sel ? ~op_b : op_b;
            carry_r <= sub_sel ? 1'b1 : cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          carry_r <= fa_co;
          res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          if (cnt == LAST) begin
            // Visible result updates only here, never on intermediate bits.
            sum       <= {fa_s, res_sr[WIDTH-1:1]};
            carry_out <= fa_co;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new addition; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 op_b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 cin  input  1  carry-in, captured when start is accepted.
REQ-008 busy  output  1  high while bits are being processed (SHIFT state).
REQ-009 done  output  1  one-cycle pulse: result valid.
REQ-010 sum  output  WIDTH  result, held stable from done until the next accepted start.
REQ-011 carry_out  output  1  final carry, held with sum.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE -> SHIFT when start=1 at a clock edge; capture op_a, op_b, cin; bit counter=0.
REQ-014 In SHIFT, each cycle SHALL process one bit pair LSB-first through a single full-adder cell.
- The carry register is updated.
- The sum bit is shifted into the result MSB.
- The operand registers shift right.
REQ-015 SHIFT -> DONE after exactly WIDTH SHIFT cycles (counter wraps at WIDTH-1); DONE -> IDLE unconditionally after one cycle.
REQ-016 Latency: start sampled at edge 0 -> busy high in cycles 1..WIDTH -> done high in cycle WIDTH+1 only.
REQ-017 Result SHALL equal (op_a + op_b + cin) mod 2^WIDTH; carry_out SHALL be bit WIDTH of the full sum.
REQ-018 start asserted in SHIFT or DONE SHALL be ignored, with no queuing; operand changes after capture SHALL have no effect.
REQ-019 sum and carry_out SHALL change only on the final SHIFT edge, not during intermediate bits.
- This requires a separate shift register internally; the output register loads at the SHIFT->DONE edge.
REQ-020 busy and done SHALL never be high in the same cycle.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, busy=0, done=0, sum=0, carry_out=0, counter=0 and carry register=0.
REQ-022 rst asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after release begins a fresh operation.

Configuration
REQ-023 Macro SERIAL_ADD_SUB_EN: when defined, an input port sub (1 bit) is added and captured with the operands.
- sub=1: result = op_a + ~op_b + 1, ignoring cin; carry_out=1 means no borrow.
- sub=0: addition with cin as specified above.
REQ-024 Without SERIAL_ADD_SUB_EN there is no sub port and the block is addition-only; all timing is identical in both builds.

Structure
REQ-025 Shared package serial_add_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the default WIDTH constant.
REQ-026 Sub-module fa_cell SHALL be the single-bit full adder (inputs a, b, ci; outputs s, co), built from two half adders plus an OR gate.
- Exactly one fa_cell instance SHALL exist.

Verification (WIDTH=8)
REQ-027 op_a=0x3C, op_b=0x55, cin=0, start pulse -> busy for 8 cycles, done in cycle 9, sum=0x91, carry_out=0.
REQ-028 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, carry_out=1; then op_a=0x00, op_b=0x00, cin=1 -> sum=0x01, carry_out=0.
REQ-029 start held high continuously for 30 cycles with op_a=0x01, op_b=0x01 -> done every 10 cycles, each time sum=0x02; no overlap of busy and done.
REQ-030 rst pulsed during SHIFT cycle 4 -> outputs 0 immediately, no done; a subsequent 0x10+0x20 -> sum=0x30.
REQ-031 Operands changed to 0xAA/0xAA during SHIFT after capturing 0x0F+0x01 -> sum=0x10 (captured values used).
REQ-032 With SERIAL_ADD_SUB_EN: sub=1, 0x10-0x01 -> sum=0x0F, carry_out=1; sub=1, 0x00-0x01 -> sum=0xFF, carry_out=0.
